// File: rtl/riscv_v_writeback_element_if.sv
// riscv_v_writeback_element_if: ALU result input and register-file write handshake bundle
interface riscv_v_writeback_element_if #(
  parameter int DATA_WIDTH = 128,
  parameter int ADDR_WIDTH = 5
);
  localparam int NUM_BYTES = DATA_WIDTH / 8;
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_data;
  logic [NUM_BYTES-1:0]  in_byte_valid;
  logic [2:0]            in_osize;
  logic                  in_is_mask;
  logic [DATA_WIDTH-1:0] in_old_dst;
  logic [ADDR_WIDTH-1:0] in_vd;
  logic                  wr_valid;
  logic                  wr_ready;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [1:0]            pending;
  modport master (
    output in_valid, in_data, in_byte_valid, in_osize, in_is_mask, in_old_dst, in_vd, wr_ready,
    input  in_ready, wr_valid, wr_addr, wr_data, pending
  );
  modport slave (
    input  in_valid, in_data, in_byte_valid, in_osize, in_is_mask, in_old_dst, in_vd, wr_ready,
    output in_ready, wr_valid, wr_addr, wr_data, pending
  );
endinterface

// File: rtl/riscv_v_writeback_element.sv
// riscv_v_writeback_element: merges ALU results with the old destination and queues register-file writes
module riscv_v_writeback_element #(
  parameter int DATA_WIDTH = 128,
  parameter int NUM_BYTES  = DATA_WIDTH / 8,
  parameter int ADDR_WIDTH = 5,
  parameter int FIFO_DEPTH = 2
) (
  input logic clk,
  input logic rst_n,
  riscv_v_writeback_element_if.slave bus
);
  logic [DATA_WIDTH-1:0] merged;
  logic [2:0]            os;
  logic                  push, pop;
  logic [1:0]            cnt_q, cnt_d;
  logic                  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [DATA_WIDTH-1:0] data_q [2];
  logic [DATA_WIDTH-1:0] data_d [2];
  logic [ADDR_WIDTH-1:0] addr_q [2];
  logic [ADDR_WIDTH-1:0] addr_d [2];
  assign bus.in_ready = cnt_q != 2'(FIFO_DEPTH);
  assign bus.wr_valid = cnt_q != 2'd0;
  assign bus.wr_addr  = addr_q[rd_ptr_q];
  assign bus.wr_data  = data_q[rd_ptr_q];
  assign bus.pending  = cnt_q;
  assign push = bus.in_valid & bus.in_ready;
  assign pop  = bus.wr_valid & bus.wr_ready;
  // mask results pack one bit per element, sampled from each element's LSB and first byte flag
  always_comb begin
    os = (bus.in_osize > 3'd4) ? 3'd0 : bus.in_osize;
    merged = bus.in_old_dst;
    for (int i = 0; i < NUM_BYTES; i++) begin
      if (bus.in_is_mask) begin
        if (i < (NUM_BYTES >> os) && bus.in_byte_valid[i << os]) merged[i] = bus.in_data[(i << os) * 8];
      end else if (bus.in_byte_valid[i]) begin
        merged[i*8 +: 8] = bus.in_data[i*8 +: 8];
      end
    end
  end
  always_comb begin
    data_d = data_q;
    addr_d = addr_q;
    if (push) begin
      data_d[wr_ptr_q] = merged;
      addr_d[wr_ptr_q] = bus.in_vd;
    end
    wr_ptr_d = wr_ptr_q ^ push;
    rd_ptr_d = rd_ptr_q ^ pop;
    cnt_d    = cnt_q + {1'b0, push} - {1'b0, pop};
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      data_q   <= '{default: '0};
      addr_q   <= '{default: '0};
    end else begin
      cnt_q    <= cnt_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      data_q   <= data_d;
      addr_q   <= addr_d;
    end
  end
endmodule

// File: tb/tb_riscv_v_writeback_element.sv
// tb_riscv_v_writeback_element: scoreboard bench with directed and randomized results
module tb_riscv_v_writeback_element;
  localparam int DW = 128;
  localparam int NB = DW / 8;
  localparam int AW = 5;
  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  bit rand_ready = 1'b0;
  exp_t exp_q[$];
  logic          stall_prev = 1'b0;
  logic [AW-1:0] held_a;
  logic [DW-1:0] held_d;
  always #5 clk = ~clk;
  riscv_v_writeback_element_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();
  riscv_v_writeback_element #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  function automatic logic [DW-1:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // reference: element size in bytes, element count, one result bit per element
  function automatic logic [DW-1:0] model(input logic [DW-1:0] d, input logic [NB-1:0] bv,
                                           input logic [2:0] os, input logic m, input logic [DW-1:0] old);
    logic [DW-1:0] r;
    int sz, n;
    r = old;
    if (!m) begin
      for (int b = 0; b < NB; b++) if (bv[b]) r[b*8 +: 8] = d[b*8 +: 8];
    end else begin
      sz = (os > 3'd4) ? 1 : (1 << os);
      n  = NB / sz;
      for (int e = 0; e < n; e++) if (bv[e*sz]) r[e] = d[e*sz*8];
    end
    return r;
  endfunction

  task automatic send(input logic [DW-1:0] d, input logic [NB-1:0] bv, input logic [2:0] os,
                      input logic m, input logic [DW-1:0] old, input logic [AW-1:0] vd);
    int n = 0;
    bus.in_valid = 1'b1; bus.in_data = d; bus.in_byte_valid = bv; bus.in_osize = os;
    bus.in_is_mask = m; bus.in_old_dst = old; bus.in_vd = vd;
    while (!bus.in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      checks++; errors++;
      $display("FAIL send_timeout: in_ready got 0 want 1");
    end else begin
      exp_q.push_back('{a: vd, d: model(d, bv, os, m, old)});
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic send_rand(input logic [AW-1:0] vd);
    send(rnd128(), NB'($urandom), 3'($urandom_range(0, 7)), 1'($urandom), rnd128(), vd);
  endtask

  task automatic set_ready(input logic v);
    @(posedge clk);
    #1 bus.wr_ready = v;
    @(negedge clk);
  endtask

  task automatic drain();
    int n = 0;
    set_ready(1'b1);
    while ((exp_q.size() != 0 || bus.pending != 2'd0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain_empty", DW'(exp_q.size()), '0);
  endtask

  initial forever begin
    @(posedge clk);
    #1 if (rand_ready) bus.wr_ready = 1'($urandom);
  end

  initial forever begin
    @(negedge clk);
    if (rst_n && stall_prev && bus.wr_valid) begin
      chk("hold_addr", DW'(bus.wr_addr), DW'(held_a));
      chk("hold_data", bus.wr_data, held_d);
    end
    if (rst_n && bus.wr_valid && bus.wr_ready) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_write: got addr %0d want none", bus.wr_addr);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("wr_addr", DW'(bus.wr_addr), DW'(e.a));
        chk("wr_data", bus.wr_data, e.d);
      end
    end
    stall_prev = rst_n && bus.wr_valid && !bus.wr_ready;
    held_a = bus.wr_addr;
    held_d = bus.wr_data;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] old_v, dat_v;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.in_byte_valid = '0; bus.in_osize = '0;
    bus.in_is_mask = 1'b0; bus.in_old_dst = '0; bus.in_vd = '0; bus.wr_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_wr_valid", DW'(bus.wr_valid), '0);
    chk("rst_pending", DW'(bus.pending), '0);
    chk("rst_in_ready", DW'(bus.in_ready), DW'(1));
    chk("rst_wr_addr", DW'(bus.wr_addr), '0);
    chk("rst_wr_data", bus.wr_data, '0);
    // fill, then reset mid-transfer: held entries must vanish
    send_rand(5'd9);
    send_rand(5'd10);
    chk("full_pending", DW'(bus.pending), DW'(2));
    chk("full_in_ready", DW'(bus.in_ready), '0);
    rst_n = 1'b0;
    #1 exp_q.delete();
    chk("midrst_pending", DW'(bus.pending), '0);
    chk("midrst_wr_valid", DW'(bus.wr_valid), '0);
    chk("midrst_in_ready", DW'(bus.in_ready), DW'(1));
    @(negedge clk);
    rst_n = 1'b1;
    bus.wr_ready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("dropped_no_write", DW'(bus.wr_valid), '0);
    end
    // byte merge
    bus.wr_ready = 1'b0;
    send({16{8'hAA}}, 16'h00FF, 3'd0, 1'b0, {16{8'h55}}, 5'd3);
    chk("nm_wr_valid", DW'(bus.wr_valid), DW'(1));
    chk("nm_wr_addr", DW'(bus.wr_addr), DW'(3));
    chk("nm_wr_data", bus.wr_data, {{8{8'h55}}, {8{8'hAA}}});
    drain();
    // mask, 32-bit elements
    bus.wr_ready = 1'b0;
    old_v = {32'h12345678, 32'h9ABCDEF0, 32'h0F0F0F0F, 32'hFFFF_FFF0};
    send({32'h1, 32'h1, 32'h0, 32'h1}, 16'h0FFF, 3'd2, 1'b1, old_v, 5'd5);
    chk("mask32_wr_data", bus.wr_data, {old_v[DW-1:4], 4'b0101});
    drain();
    // mask, single 128-bit element
    bus.wr_ready = 1'b0;
    old_v = rnd128();
    old_v[0] = 1'b0;
    dat_v = rnd128();
    dat_v[0] = 1'b1;
    send(dat_v, 16'hFFFF, 3'd4, 1'b1, old_v, 5'd7);
    chk("mask128_wr_data", bus.wr_data, {old_v[DW-1:1], 1'b1});
    drain();
    // backpressure: third result must wait, head must stay stable
    bus.wr_ready = 1'b0;
    send_rand(5'd1);
    send_rand(5'd2);
    fork
      send_rand(5'd3);
      begin
        repeat (3) begin
          chk("bp_in_ready", DW'(bus.in_ready), '0);
          chk("bp_pending", DW'(bus.pending), DW'(2));
          chk("bp_head_addr", DW'(bus.wr_addr), DW'(1));
          @(negedge clk);
        end
        set_ready(1'b1);
      end
    join
    drain();
    // streaming with the register file always ready
    for (int i = 0; i < 8; i++) begin
      send_rand(AW'(i));
      chk("stream_pending", DW'(bus.pending), DW'(1));
      chk("stream_in_ready", DW'(bus.in_ready), DW'(1));
    end
    drain();
    // randomized traffic and backpressure
    rand_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      send_rand(AW'($urandom));
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end
    rand_ready = 1'b0;
    drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
